dsp_mac_slice_gen: RTL
======================

Name: dsp_mac_slice_gen

Overview:
Parametrised, fully pipelined DSP slice that succeeds the fixed-width 18x18/48 slice. It provides a pre-adder, a multiplier and a post-adder/accumulator, keeps the same 8-bit opmode semantics, and carries a valid signal through the pipeline. New in this generation: configurable widths, a global stall enable, optional unsigned saturation, and a sticky overflow flag. It cascades through pcin/pcout and bcout in MAC chains.

Parameters:
A_WIDTH, 18, A operand width
B_WIDTH, 18, B/D operand and pre-adder width
P_WIDTH, 48, C/P/PCIN width; must be >= A_WIDTH+B_WIDTH
CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" uses opmode[5], "CARRYIN" uses the carryin port
SAT_EN, 0, 1 = unsigned saturation on post-add carry/borrow

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ce  in  1  global enable; 0 freezes every register
in_valid  in  1  operands valid this cycle
a  in  A_WIDTH  multiplier operand
b  in  B_WIDTH  multiplier/pre-adder operand
d  in  B_WIDTH  pre-adder operand
c  in  P_WIDTH  post-adder operand
pcin  in  P_WIDTH  cascade input
carryin  in  1  external carry-in
opmode  in  8  operation select
clr_ovf  in  1  clears the sticky overflow flag
p  out  P_WIDTH  result register
pcout  out  P_WIDTH  equals p
m  out  A_WIDTH+B_WIDTH  multiplier register
bcout  out  B_WIDTH  stage-1 b register
carryout  out  1  registered post-add carry/borrow
ovf  out  1  sticky overflow
out_valid  out  1  p holds a new result

Behaviour:
- Reset: when rst=1 at a clock edge, all registers clear to 0 regardless of ce. This covers p, m, bcout, carryout, ovf, out_valid and every valid/opmode stage.
- Stall: ce=0 holds every register. rst takes priority over ce.
- Latency: a beat accepted with in_valid=1 in cycle N gives out_valid=1 and p updated in cycle N+3, provided ce=1 throughout. Throughput is 1 beat per cycle.
- Stage 1 registers: a, b, c, d, opmode, cin, and valid.
  - cin = opmode[5] or carryin, per CARRYINSEL.
- Stage 2 (pre-adder and multiplier):
  - If opmode[4]=1, bsel = d-b when opmode[6]=1, otherwise d+b. The result is truncated to B_WIDTH.
  - If opmode[4]=0, bsel = b.
  - m <= a*bsel, unsigned, full width.
  - The concatenation {d,a,b} is zero-extended or truncated to P_WIDTH. It, c, opmode, cin and valid pass through to stage 3.
- Stage 3 (post-adder), evaluated at P_WIDTH+1 bits:
  - X select by opmode[1:0]: 0 = zero, 1 = m (zero-extended), 2 = p, 3 = the {d,a,b} concatenation.
  - Z select by opmode[3:2]: 0 = zero, 1 = pcin (unregistered), 2 = p, 3 = c.
  - opmode[7]=0: r = Z + X + cin.
  - opmode[7]=1: r = Z - (X + cin).
  - carryout <= r[P_WIDTH].
- Stage 3 update rule: p, carryout and out_valid update only when the stage-2 valid is 1 and ce=1.
  - Otherwise p and carryout hold and out_valid <= 0 (when ce=1).
  - Feedback through X=p or Z=p uses the current p register, so back-to-back valid beats accumulate.
- Saturation:
  - SAT_EN=0: p <= r[P_WIDTH-1:0].
  - SAT_EN=1 and r[P_WIDTH]=1: an add gives p <= all ones; a subtract gives p <= 0.
- ovf:
  - Set on any stage-3 update with r[P_WIDTH]=1.
  - Cleared by clr_ovf. If set and clear occur in the same cycle, set wins.
  - Holds otherwise.
- Opmode 2'b11 on both X and Z is legal; no illegal codes exist.

Test Plan:
1. Multiply: a=3, b=5, opmode=8'h01, Z=0, single valid beat -> out_valid pulses at N+3, p=15, m=15, carryout=0.
2. Pre-subtract: d=10, b=4, a=2, opmode=8'h51 -> p=12. Then opmode=8'h11 with the same operands -> p=28.
3. Accumulate: rst, then 4 consecutive beats with a=1, b=1, opmode=8'h09 -> p=1, 2, 3, 4 on consecutive cycles, out_valid held at 1 for 4 cycles.
4. Borrow: c=5, a=1, b=7, opmode=8'h8D.
   - SAT_EN=0 -> p=2^48-2, carryout=1, ovf=1.
   - SAT_EN=1 -> p=0.
   - Then clr_ovf=1 for one cycle -> ovf=0.
5. Carry saturation, SAT_EN=1: c=2^48-1 and X = concatenation with b=1 (opmode=8'h0F) -> p=2^48-1, carryout=1, ovf=1.
6. Stall and reset: drop ce for 2 cycles with a beat in stage 2 -> result appears at N+5 unchanged. Assert rst mid-pipeline -> next cycle p=0, out_valid=0, ovf=0, and no stale beat emerges.

Source files
------------

// File: rtl/dsp_mac_slice_gen.sv
// Parametrised three-stage DSP MAC slice: pre-adder, unsigned multiplier,
// post-adder/accumulator with optional unsigned saturation, sticky overflow
// and pcin/pcout/bcout cascade ports.
module dsp_mac_slice_gen #(
  parameter int unsigned A_WIDTH    = 18,
  parameter int unsigned B_WIDTH    = 18,
  parameter int unsigned P_WIDTH    = 48,
  parameter string       CARRYINSEL = "OPMODE5",
  parameter bit          SAT_EN     = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       in_valid,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic [B_WIDTH-1:0]         d,
  input  logic [P_WIDTH-1:0]         c,
  input  logic [P_WIDTH-1:0]         pcin,
  input  logic                       carryin,
  input  logic [7:0]                 opmode,
  input  logic                       clr_ovf,
  output logic [P_WIDTH-1:0]         p,
  output logic [P_WIDTH-1:0]         pcout,
  output logic [A_WIDTH+B_WIDTH-1:0] m,
  output logic [B_WIDTH-1:0]         bcout,
  output logic                       carryout,
  output logic                       ovf,
  output logic                       out_valid
);

  localparam int unsigned M_W   = A_WIDTH + B_WIDTH;
  localparam int unsigned CAT_W = 2 * B_WIDTH + A_WIDTH;
  localparam int unsigned PX_W  = P_WIDTH + 1;
  localparam bit          USE_CIN_PORT = (CARRYINSEL == "CARRYIN");

  // Stage 1 registers
  logic [A_WIDTH-1:0] a1;
  logic [B_WIDTH-1:0] b1;
  logic [B_WIDTH-1:0] d1;
  logic [P_WIDTH-1:0] c1;
  logic [7:0]         op1;
  logic               cin1;
  logic               v1;

  // Stage 2 registers
  logic [P_WIDTH-1:0] cat2;
  logic [P_WIDTH-1:0] c2;
  logic [7:0]         op2;
  logic               cin2;
  logic               v2;

  // Stage 2 combinational
  logic [B_WIDTH-1:0]         bsel_c;
  logic [CAT_W+P_WIDTH-1:0]   cat_ext_c;

  // Stage 3 combinational
  logic [PX_W-1:0]    x_c;
  logic [PX_W-1:0]    z_c;
  logic [PX_W-1:0]    r_c;
  logic [P_WIDTH-1:0] p_next_c;

  logic cin_sel_c;

  assign cin_sel_c = USE_CIN_PORT ? carryin : opmode[5];
  assign bcout     = b1;
  assign pcout     = p;

  // Stage 1: capture operands, opmode, carry-in and valid
  always_ff @(posedge clk) begin
    if (rst) begin
      a1   <= '0;
      b1   <= '0;
      d1   <= '0;
      c1   <= '0;
      op1  <= '0;
      cin1 <= 1'b0;
      v1   <= 1'b0;
    end else if (ce) begin
      a1   <= a;
      b1   <= b;
      d1   <= d;
      c1   <= c;
      op1  <= opmode;
      cin1 <= cin_sel_c;
      v1   <= in_valid;
    end
  end

  // Pre-adder select and {d,a,b} concatenation fitted to P_WIDTH
  always_comb begin
    bsel_c = b1;
    if (op1[4]) begin
      bsel_c = op1[6] ? (d1 - b1) : (d1 + b1);
    end
    cat_ext_c = {{P_WIDTH{1'b0}}, d1, a1, b1};
  end

  // Stage 2: multiply and pass-through of post-adder controls
  always_ff @(posedge clk) begin
    if (rst) begin
      m    <= '0;
      cat2 <= '0;
      c2   <= '0;
      op2  <= '0;
      cin2 <= 1'b0;
      v2   <= 1'b0;
    end else if (ce) begin
      m    <= M_W'(a1) * M_W'(bsel_c);
      cat2 <= cat_ext_c[P_WIDTH-1:0];
      c2   <= c1;
      op2  <= op1;
      cin2 <= cin1;
      v2   <= v1;
    end
  end

  // Post-adder operand muxes, add/subtract and saturation
  always_comb begin
    x_c = '0;
    z_c = '0;
    case (op2[1:0])
      2'd0: x_c = '0;
      2'd1: x_c = PX_W'(m);
      2'd2: x_c = PX_W'(p);
      default: x_c = PX_W'(cat2);
    endcase
    case (op2[3:2])
      2'd0: z_c = '0;
      2'd1: z_c = PX_W'(pcin);
      2'd2: z_c = PX_W'(p);
      default: z_c = PX_W'(c2);
    endcase
    if (op2[7]) begin
      r_c = z_c - (x_c + PX_W'(cin2));
    end else begin
      r_c = z_c + x_c + PX_W'(cin2);
    end
    p_next_c = r_c[P_WIDTH-1:0];
    if (SAT_EN && r_c[P_WIDTH]) begin
      p_next_c = op2[7] ? '0 : '1;
    end
  end

  // Stage 3: result, carry, sticky overflow (set beats clear) and valid
  always_ff @(posedge clk) begin
    if (rst) begin
      p         <= '0;
      carryout  <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= v2;
      if (v2) begin
        p        <= p_next_c;
        carryout <= r_c[P_WIDTH];
      end
      if (v2 && r_c[P_WIDTH]) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
